// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency: accept edge -> out_valid is XLEN+2 cycles for normal ops, 2 cycles for special or illegal cases.
// Backpressure: single op in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk/rstn (async active-low), flush (sync abandon), in_valid/in_ready + mode/number1/number2 in,
//        out_valid/out_ready + answer/error out. error[0] div-by-zero, [1] signed overflow,
//        [2] illegal mode, [3] always 0.
module mdu_iterative #(
    parameter int XLEN   = 32,
    parameter int MODE_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] mode,
    input  logic [XLEN-1:0]   number1,
    input  logic [XLEN-1:0]   number2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   answer,
    output logic [3:0]        error
);

    localparam int CW = $clog2(XLEN);
    localparam logic [MODE_W-1:0] MODE_BASE = MODE_W'(8'h40);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state;
    logic [MODE_W-1:0]   mode_q;
    logic [XLEN-1:0]     n1_q;
    logic [XLEN-1:0]     n2_q;
    // Multiply: {upper accumulator, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   prod;
    // Multiplicand (multiply) or divisor (divide), already made non-negative.
    logic [XLEN-1:0]     opnd;
    logic [CW-1:0]       count;
    logic                neg_res;
    logic                neg_rem;
    logic                special;
    logic [XLEN-1:0]     spec_ans;
    logic [3:0]          spec_err;

    // Low three mode bits select the op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU.
    logic [2:0] op;
    logic       legal;
    logic       op_mul;
    assign op     = mode_q[2:0];
    assign legal  = (mode_q[MODE_W-1:3] == MODE_BASE[MODE_W-1:3]);
    assign op_mul = ~op[2];

    // rstn gates in_ready so it reads 0 throughout reset, not just after the first edge.
    assign in_ready = rstn && (state == S_IDLE);

    // ---------------- PREP: operand signs, magnitudes, special cases ----------------
    logic            sgn1, sgn2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div0, ovf, spec_hit;
    logic [XLEN-1:0] spec_ans_d;
    logic [3:0]      spec_err_d;

    always_comb begin
        sgn1 = ((op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6)) && n1_q[XLEN-1];
        sgn2 = ((op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && n2_q[XLEN-1];
        // Negating the most negative value wraps to itself, which is the right unsigned magnitude.
        abs1 = sgn1 ? -n1_q : n1_q;
        abs2 = sgn2 ? -n2_q : n2_q;
        div0 = op[2] && (n2_q == '0);
        ovf  = ((op == 3'd4) || (op == 3'd6)) &&
               (n1_q == {1'b1, {(XLEN-1){1'b0}}}) && (n2_q == '1);
        spec_hit   = !legal || div0 || ovf;
        spec_ans_d = '0;
        spec_err_d = 4'b0000;
        if (!legal) begin
            spec_ans_d = '0;
            spec_err_d = 4'b0100;
        end else if (div0) begin
            spec_ans_d = op[1] ? n1_q : '1;
            spec_err_d = 4'b0001;
        end else if (ovf) begin
            spec_ans_d = op[1] ? '0 : n1_q;
            spec_err_d = 4'b0010;
        end
    end

    // ---------------- CALC: one multiply or divide step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opnd};
        mul_next = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
        // The shifted partial remainder needs XLEN+1 bits when the divisor has its top bit set;
        // a successful subtract always leaves less than the divisor, so XLEN bits suffice after.
        rem_sh   = prod[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh[XLEN-1:0] - opnd;
        if (rem_sh >= {1'b0, opnd}) begin
            div_next = {rem_diff, prod[XLEN-2:0], 1'b1};
        end else begin
            div_next = {prod[2*XLEN-2:0], 1'b0};
        end
    end

    // ---------------- FIX: sign correction and word select ----------------
    logic [2*XLEN-1:0] mul_res;
    logic [XLEN-1:0]   quo_res, rem_res, fix_ans;
    logic [3:0]        fix_err;

    always_comb begin
        mul_res = neg_res ? -prod : prod;
        quo_res = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_res = neg_rem ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        fix_ans = '0;
        fix_err = 4'b0000;
        if (special) begin
            fix_ans = spec_ans;
            fix_err = spec_err;
        end else if (op_mul) begin
            fix_ans = (op == 3'd0) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
        end else begin
            fix_ans = op[1] ? rem_res : quo_res;
        end
    end

    // ---------------- Control FSM and registered outputs ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            n1_q      <= '0;
            n2_q      <= '0;
            prod      <= '0;
            opnd      <= '0;
            count     <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            special   <= 1'b0;
            spec_ans  <= '0;
            spec_err  <= 4'b0000;
            out_valid <= 1'b0;
            answer    <= '0;
            error     <= 4'b0000;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            answer    <= '0;
            error     <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        n1_q   <= number1;
                        n2_q   <= number2;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res  <= sgn1 ^ sgn2;
                    neg_rem  <= sgn1;
                    opnd     <= op_mul ? abs1 : abs2;
                    prod     <= {{XLEN{1'b0}}, (op_mul ? abs2 : abs1)};
                    count    <= CW'(XLEN - 1);
                    special  <= spec_hit;
                    spec_ans <= spec_ans_d;
                    spec_err <= spec_err_d;
                    // Special results pass through FIX so answer/error are loaded in one place.
                    state    <= spec_hit ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    prod <= op_mul ? mul_next : div_next;
                    if (count == '0) begin
                        state <= S_FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                S_FIX: begin
                    answer    <= fix_ans;
                    error     <= fix_err;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: vector table plus backpressure, flush and reset sequences.
// Latency is counted in rising edges from the accept edge to the first out_valid sample.
// Inputs are driven 1 time unit after a rising edge and outputs sampled at the same point.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  mode = 8'h0;
    logic [31:0] number1 = 32'h0;
    logic [31:0] number2 = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] answer;
    logic [3:0]  error;

    int tests = 0;
    int fails = 0;

    mdu_iterative #(.XLEN(32), .MODE_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .number1   (number1),
        .number2   (number2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .answer    (answer),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ans;
        logic [3:0]  err;
        logic [7:0]  lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic [3:0] e, input logic [7:0] l);
        vec_t v;
        v.mode = m; v.a = a; v.b = b; v.ans = r; v.err = e; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op, wait for acceptance, then wait (bounded) for out_valid.
    task automatic issue(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ans, output logic [3:0] err, output int lat);
        mode = m; number1 = a; number2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs after accept: they must not leak into the result.
        mode = 8'($urandom); number1 = $urandom; number2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        ans = answer;
        err = error;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ans, held;
        logic [3:0]  err;
        int          lat, seen;

        // 8'h40 MUL, 41 MULH, 42 MULHSU, 43 MULHU, 44 DIV, 45 DIVU, 46 REM, 47 REMU
        vq.push_back(mk(8'h44, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b0000, 8'd34));
        vq.push_back(mk(8'h46, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 4'b0000, 8'd34));
        vq.push_back(mk(8'h45, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 4'b0000, 8'd34));
        vq.push_back(mk(8'h45, 32'd100,      32'h0,        32'hFFFFFFFF, 4'b0001, 8'd2));
        vq.push_back(mk(8'h47, 32'd100,      32'h0,        32'd100,      4'b0001, 8'd2));
        vq.push_back(mk(8'h44, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0010, 8'd2));
        vq.push_back(mk(8'h46, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b0010, 8'd2));
        vq.push_back(mk(8'h40, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 8'd34));
        vq.push_back(mk(8'h41, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 8'd34));
        vq.push_back(mk(8'h43, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0000, 8'd34));
        vq.push_back(mk(8'h42, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 8'd34));
        vq.push_back(mk(8'h40, 32'd3,        32'd5,        32'd15,       4'b0000, 8'd34));
        vq.push_back(mk(8'h41, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 8'd34));
        vq.push_back(mk(8'h42, 32'h80000000, 32'h2,        32'hFFFFFFFF, 4'b0000, 8'd34));
        vq.push_back(mk(8'h43, 32'hFFFFFFFF, 32'h2,        32'h00000001, 4'b0000, 8'd34));
        vq.push_back(mk(8'h44, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0000, 8'd34));
        vq.push_back(mk(8'h46, 32'd7,        32'hFFFFFFFE, 32'h00000001, 4'b0000, 8'd34));
        vq.push_back(mk(8'h44, 32'h80000000, 32'h2,        32'hC0000000, 4'b0000, 8'd34));
        vq.push_back(mk(8'h45, 32'd100,      32'd7,        32'd14,       4'b0000, 8'd34));
        vq.push_back(mk(8'h47, 32'd100,      32'd7,        32'd2,        4'b0000, 8'd34));
        vq.push_back(mk(8'h47, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 4'b0000, 8'd34));
        vq.push_back(mk(8'h44, 32'd7,        32'h0,        32'hFFFFFFFF, 4'b0001, 8'd2));
        vq.push_back(mk(8'h46, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 4'b0001, 8'd2));
        vq.push_back(mk(8'h48, 32'd1,        32'd2,        32'h00000000, 4'b0100, 8'd2));
        vq.push_back(mk(8'h3F, 32'd1,        32'd2,        32'h00000000, 4'b0100, 8'd2));

        // Reset state, sampled mid-reset.
        #12;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset answer", answer, 32'h0);
        check("reset error", 32'(error), 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle in_ready", 32'(in_ready), 32'd1);

        // Vector table.
        foreach (vq[i]) begin
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            issue(vq[i].mode, vq[i].a, vq[i].b, ans, err, lat);
            check($sformatf("vec%0d answer", i), ans, vq[i].ans);
            check($sformatf("vec%0d error", i), 32'(err), 32'(vq[i].err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vq[i].lat));
            take_result();
        end

        // Backpressure: result held while out_ready is low.
        issue(8'h44, 32'hFFFFFFF9, 32'h2, ans, err, lat);
        check("bp answer", ans, 32'hFFFFFFFD);
        held = answer;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold answer c%0d", c), answer, held);
            check($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp hold in_ready c%0d", c), 32'(in_ready), 32'd0);
        end
        take_result();
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        issue(8'h05, 32'd9, 32'd9, ans, err, lat);
        check("bp illegal answer", ans, 32'h0);
        check("bp illegal error", 32'(err), 32'b0100);
        check("bp illegal latency", 32'(lat), 32'd2);
        take_result();

        // Flush during the 10th CALC cycle; a simultaneous in_valid must be ignored.
        mode = 8'h40; number1 = 32'd11; number2 = 32'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush busy in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_valid = 1'b1; mode = 8'h40; number1 = 32'd3; number2 = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no result", 32'(seen), 32'd0);
        check("flush still idle", 32'(in_ready), 32'd1);

        // Reset pulse mid-CALC clears outputs asynchronously.
        issue(8'h45, 32'd5, 32'd0, ans, err, lat);
        check("pre-reset error", 32'(err), 32'b0001);
        take_result();
        mode = 8'h45; number1 = 32'd1000; number2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst in_ready", 32'(in_ready), 32'd0);
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst answer", answer, 32'h0);
        check("arst error", 32'(error), 32'h0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        issue(8'h40, 32'd3, 32'd5, ans, err, lat);
        check("post-reset mul answer", ans, 32'd15);
        check("post-reset mul error", 32'(err), 32'h0);
        check("post-reset mul latency", 32'(lat), 32'd34);
        take_result();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
